// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an 8-bit bidirectional shift datapath.
// Accepts LOAD/SHIFT/ROTATE commands and steps the register one bit per cycle.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   cmd_valid/ready  command handshake; accepted when both are high at an edge
//   cmd_op           000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR
//   cmd_amt          number of single-bit steps for shift/rotate ops
//   cmd_data         load value (LOAD only)
//   fill_bit         bit shifted in by SHL/SHR
//   data_out         current register contents
//   busy             a multi-cycle shift is in progress
//   done, cmd_err    one-cycle completion / reserved-opcode pulses
//   sr_enable        a shift step happens at the end of this cycle
//   sr_direction     0 = left, 1 = right; held between operations
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             fill_bit,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done,
   output logic             cmd_err,
   output logic             sr_enable,
   output logic             sr_direction
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;

   localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);
   localparam logic [AMT_W-1:0] AMT_ZERO = '0;

   state_t           state_q, state_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             dir_q, dir_d;
   logic             rot_q, rot_d;
   logic             fill_q, fill_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             accept;
   logic             in_l;
   logic             in_r;
   logic [WIDTH-1:0] step;

   // Bit entering the vacated end: wrapped-around bit for rotates,
   // captured fill bit for shifts.
   assign in_l = rot_q ? data_q[WIDTH-1] : fill_q;
   assign in_r = rot_q ? data_q[0] : fill_q;
   assign step = dir_q ? {in_r, data_q[WIDTH-1:1]}
                       : {data_q[WIDTH-2:0], in_l};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      dir_d     = dir_q;
      rot_d     = rot_q;
      fill_d    = fill_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cmd_ready = (state_q == IDLE);
      busy      = (state_q == SHIFT);
      sr_enable = (state_q == SHIFT);
      accept    = cmd_valid & cmd_ready;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               done_d = 1'b1;
               case (cmd_op)
                  OP_NOP: ;
                  OP_LOAD: data_d = cmd_data;
                  OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                     // Zero-length shifts complete like a NOP.
                     if (cmd_amt != AMT_ZERO) begin
                        state_d = SHIFT;
                        cnt_d   = cmd_amt;
                        dir_d   = cmd_op[0];
                        rot_d   = cmd_op[2];
                        fill_d  = fill_bit;
                        done_d  = 1'b0;
                     end
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         SHIFT: begin
            data_d = step;
            cnt_d  = cnt_q - AMT_ONE;
            if (cnt_q == AMT_ONE) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         dir_q   <= 1'b0;
         rot_q   <= 1'b0;
         fill_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         rot_q   <= rot_d;
         fill_q  <= fill_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign data_out     = data_q;
   assign done         = done_q;
   assign cmd_err      = err_q;
   assign sr_direction = dir_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'b000;
   logic [2:0] cmd_amt = 3'd0;
   logic [7:0] cmd_data = 8'h00;
   logic       fill_bit = 1'b0;
   logic [7:0] data_out;
   logic       busy, done, cmd_err, sr_enable, sr_direction;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_amt(cmd_amt),
      .cmd_data(cmd_data), .fill_bit(fill_bit),
      .data_out(data_out), .busy(busy), .done(done),
      .cmd_err(cmd_err), .sr_enable(sr_enable),
      .sr_direction(sr_direction)
   );

   // Present a command for one cycle (caller ensures cmd_ready=1),
   // then scramble the inputs to show they were captured.
   task automatic drive(input logic [2:0] op, input logic [2:0] amt,
                        input logic [7:0] data, input logic fill);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_amt   = amt;
      cmd_data  = data;
      fill_bit  = fill;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      cmd_amt   = 3'd0;
      cmd_data  = ~data;
      fill_bit  = ~fill;
   endtask

   // Return cycles after acceptance until done is seen (99 on timeout).
   task automatic wait_done(output int n);
      n = 99;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic load(input logic [7:0] v);
      drive(3'b001, 3'd0, v, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({data_out, cmd_ready, busy, done, cmd_err, sr_enable, sr_direction}
          !== {8'h00, 1'b1, 5'b0}) begin
         errors++;
         $display("FAIL reset: got data=%h rdy=%b busy=%b done=%b err=%b en=%b dir=%b",
                  data_out, cmd_ready, busy, done, cmd_err, sr_enable, sr_direction);
      end
   endtask

   task automatic test_load;
      drive(3'b001, 3'd0, 8'hAA, 1'b0);
      @(negedge clk);
      checks++;
      if ({data_out, done, busy, cmd_err} !== {8'hAA, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL load: got data=%h done=%b busy=%b err=%b want AA 1 0 0",
                  data_out, done, busy, cmd_err);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL load_done_pulse: got done=%b want 0", done);
      end
   endtask

   task automatic test_shl;
      logic [7:0] exp [4] = '{8'hAA, 8'h54, 8'hA8, 8'h50};
      drive(3'b010, 3'd3, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({sr_enable, sr_direction, cmd_ready, busy, done, data_out}
             !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, exp[i]}) begin
            errors++;
            $display("FAIL shl_step%0d: got en=%b dir=%b rdy=%b busy=%b done=%b data=%h want data=%h",
                     i, sr_enable, sr_direction, cmd_ready, busy, done, data_out, exp[i]);
         end
      end
      @(negedge clk);
      checks++;
      if ({done, cmd_ready, sr_enable, busy, data_out}
          !== {1'b1, 1'b1, 1'b0, 1'b0, exp[3]}) begin
         errors++;
         $display("FAIL shl_done: got done=%b rdy=%b en=%b busy=%b data=%h want 1 1 0 0 50",
                  done, cmd_ready, sr_enable, busy, data_out);
      end
   endtask

   task automatic test_rotate;
      int n;
      load(8'hAA);
      drive(3'b011, 3'd1, 8'h00, 1'b0);
      wait_done(n);
      checks++;
      if (n !== 2 || data_out !== 8'h55 || sr_direction !== 1'b1) begin
         errors++;
         $display("FAIL shr1: got n=%0d data=%h dir=%b want 2 55 1", n, data_out, sr_direction);
      end
      drive(3'b011, 3'd2, 8'h00, 1'b1);
      wait_done(n);
      checks++;
      if (n !== 3 || data_out !== 8'hD5) begin
         errors++;
         $display("FAIL shr2_fill1: got n=%0d data=%h want 3 D5", n, data_out);
      end
      load(8'hA5);
      drive(3'b100, 3'd4, 8'h00, 1'b1);
      wait_done(n);
      checks++;
      if (n !== 5 || data_out !== 8'h5A || sr_direction !== 1'b0) begin
         errors++;
         $display("FAIL rol4: got n=%0d data=%h dir=%b want 5 5A 0", n, data_out, sr_direction);
      end
      load(8'h81);
      drive(3'b101, 3'd7, 8'h00, 1'b0);
      wait_done(n);
      checks++;
      if (n !== 8 || data_out !== 8'h03) begin
         errors++;
         $display("FAIL ror7: got n=%0d data=%h want 8 03", n, data_out);
      end
   endtask

   task automatic test_zero_and_reserved;
      load(8'h3C);
      drive(3'b010, 3'd0, 8'h00, 1'b1);
      @(negedge clk);
      checks++;
      if ({done, busy, cmd_err, data_out} !== {1'b1, 1'b0, 1'b0, 8'h3C}) begin
         errors++;
         $display("FAIL shl0: got done=%b busy=%b err=%b data=%h want 1 0 0 3C",
                  done, busy, cmd_err, data_out);
      end
      drive(3'b110, 3'd3, 8'hEE, 1'b0);
      @(negedge clk);
      checks++;
      if ({done, cmd_err, busy, data_out} !== {1'b1, 1'b1, 1'b0, 8'h3C}) begin
         errors++;
         $display("FAIL reserved: got done=%b err=%b busy=%b data=%h want 1 1 0 3C",
                  done, cmd_err, busy, data_out);
      end
      @(negedge clk);
      checks++;
      if ({done, cmd_err} !== 2'b00) begin
         errors++;
         $display("FAIL reserved_pulse: got done=%b err=%b want 0 0", done, cmd_err);
      end
   endtask

   task automatic test_back_to_back;
      drive(3'b011, 3'd5, 8'h00, 1'b0);
      cmd_valid = 1'b1;
      cmd_op    = 3'b001;
      cmd_data  = 8'hFF;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (cmd_ready !== 1'b0 || data_out === 8'hFF || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold%0d: got rdy=%b data=%h done=%b want rdy=0 no FF",
                     i, cmd_ready, data_out, done);
         end
      end
      @(negedge clk);
      checks++;
      if ({done, cmd_ready, data_out} !== {1'b1, 1'b1, 8'h01}) begin
         errors++;
         $display("FAIL b2b_done: got done=%b rdy=%b data=%h want 1 1 01",
                  done, cmd_ready, data_out);
      end
      @(posedge clk);
      #1;
      cmd_data = 8'h11;
      @(negedge clk);
      checks++;
      if ({done, data_out} !== {1'b1, 8'hFF}) begin
         errors++;
         $display("FAIL b2b_load: got done=%b data=%h want 1 FF", done, data_out);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, data_out} !== {1'b1, 8'h11}) begin
         errors++;
         $display("FAIL b2b_load2: got done=%b data=%h want 1 11", done, data_out);
      end
   endtask

   task automatic test_reset_abort;
      int seen = 0;
      load(8'h0F);
      drive(3'b010, 3'd6, 8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({data_out, busy, cmd_ready, sr_enable, done}
          !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL abort: got data=%h busy=%b rdy=%b en=%b done=%b want 00 0 1 0 0",
                  data_out, busy, cmd_ready, sr_enable, done);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done pulses want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_shl();
      test_rotate();
      test_zero_and_reserved();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller that sequences an 8-bit bidirectional shift datapath. It accepts load, shift and rotate commands over a valid/ready handshake and steps the register one bit per cycle for the commanded amount. It reports completion with a done pulse and exports the per-cycle shift controls (enable, direction) so a companion shift_register instance can be driven in lockstep. It sits between the command source (CPU-side register block or test sequencer) and the shift datapath.

Parameters:
WIDTH, 8, data register width in bits (minimum 2).
AMT_W, 3, width of the shift-amount field; the amount range is 0..2^AMT_W-1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  a command is presented.
cmd_ready  output  1  the block can accept a command this cycle.
cmd_op  input  3  opcode: 000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110/111 reserved.
cmd_amt  input  AMT_W  number of single-bit steps for SHL/SHR/ROL/ROR.
cmd_data  input  WIDTH  load value, used by LOAD only.
fill_bit  input  1  bit shifted in by SHL/SHR.
data_out  output  WIDTH  current register contents.
busy  output  1  a multi-cycle shift is in progress.
done  output  1  one-cycle completion pulse.
cmd_err  output  1  one-cycle pulse when a reserved opcode is accepted.
sr_enable  output  1  a shift step occurs at the end of this cycle.
sr_direction  output  1  0 = left (toward MSB), 1 = right; held between operations.

Behaviour:
- Reset (synchronous, while reset=1 at an edge):
  - State goes to IDLE.
  - data_out=0, cmd_ready=1, busy=0, done=0, cmd_err=0, sr_enable=0, sr_direction=0.
  - Any in-flight shift is aborted; no done pulse is generated for it.
- States:
  - IDLE: cmd_ready=1, busy=0.
  - SHIFT: cmd_ready=0, busy=1, sr_enable=1.
- Acceptance:
  - A command is accepted at the edge ending any cycle in which cmd_valid=1 and cmd_ready=1. Call that accept cycle C0.
  - cmd_op, cmd_amt and fill_bit are captured at acceptance; later input changes do not affect the operation.
- NOP, LOAD, reserved opcodes, or shifts with cmd_amt=0:
  - Stay in IDLE.
  - LOAD writes data_out<=cmd_data at the end of C0.
  - All other cases leave data_out unchanged.
  - done=1 in cycle C0+1. Reserved opcodes also raise cmd_err=1 in C0+1.
- SHL/SHR/ROL/ROR with amt N>0:
  - Enter SHIFT with a down-counter loaded to N. sr_direction is set (left for SHL/ROL, right for SHR/ROR) and is valid from C0+1.
  - Cycles C0+1..C0+N are in SHIFT. At the end of each, data_out performs one step and the counter decrements.
  - The block leaves SHIFT at the end of cycle C0+N.
  - done=1 in cycle C0+N+1, which is the first cycle the final value is visible. cmd_ready=1 in the same cycle.
- Step definitions (W = WIDTH):
  - SHL: {d[W-2:0], fill}
  - SHR: {fill, d[W-1:1]}
  - ROL: {d[W-2:0], d[W-1]}
  - ROR: {d[0], d[W-1:1]}
- Back-to-back commands: a command may be accepted in the done cycle. Zero bubbles occur between single-cycle commands.
- cmd_valid held high during SHIFT is ignored until cmd_ready returns to 1.
- done and cmd_err are registered and are never high for more than one consecutive cycle per command.

Test Plan:
1. Reset, then LOAD cmd_data=0xAA -> data_out=0xAA and done=1 in the cycle after acceptance; busy stays 0; cmd_err=0.
2. From 0xAA, SHL amt=3 fill=0 -> sr_enable=1 and sr_direction=0 for exactly 3 cycles; cmd_ready=0 during those cycles; data_out steps 0x54, 0xA8, 0x50; done in cycle C0+4.
3. From 0xAA, SHR amt=1 fill=0 -> data_out=0x55, done in C0+2. Then ROL amt=4 on a loaded 0xA5 -> 0x5A. Then ROR amt=7 on 0x81 -> 0x03.
4. SHL amt=0 on 0x3C -> done in C0+1 with data_out unchanged. Reserved op 110 -> done and cmd_err both 1 in C0+1; data_out unchanged.
5. cmd_valid held high with LOAD 0xFF while a SHR amt=5 runs -> the LOAD is accepted only in the done cycle; data_out=0xFF one cycle later.
6. Assert reset during cycle C0+2 of a SHL amt=6 -> next cycle data_out=0x00, busy=0, cmd_ready=1, and no done pulse follows.
